// File: rtl/toggle_bank.sv
`default_nettype none
// ============================================================================
// Module   : toggle_bank
// Purpose  : Bank of WIDTH T flip-flops with hold / toggle / load / count
//            operation, a combinational terminal-count flag, a registered
//            "changed" flag and a saturating count of changing edges.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1      sole clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   mode     in   2      00 hold, 01 toggle, 10 load, 11 count
//   t        in   WIDTH  per-bit toggle mask (toggle mode)
//   d        in   WIDTH  parallel load data (load mode)
//   up       in   1      count direction (count mode): 1 up, 0 down
//   clr_cnt  in   1      synchronous clear of tog_cnt
//   q        out  WIDTH  flip-flop bank state
//   tc       out  1      terminal count (combinational)
//   chg      out  1      q changed on the most recent rising edge
//   tog_cnt  out  CNT_W  saturating count of edges on which q changed
// ============================================================================
module toggle_bank #(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    input  logic             up,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             chg,
    output logic [CNT_W-1:0] tog_cnt
);

    localparam logic [1:0] c_mode_hold   = 2'b00;
    localparam logic [1:0] c_mode_toggle = 2'b01;
    localparam logic [1:0] c_mode_load   = 2'b10;
    localparam logic [1:0] c_mode_count  = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic             r_chg;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_tgl_up;
    logic [WIDTH-1:0] w_tgl_dn;
    logic [WIDTH-1:0] w_q_nx;
    logic             w_chg;
    logic             w_cnt_full;

    // Counting is built as a T-FF ripple chain: a bit toggles when every bit
    // below it is 1 (up) or 0 (down). Bit 0 always toggles while counting.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        if (i == 0) begin : g_lsb
            assign w_tgl_up[i] = 1'b1;
            assign w_tgl_dn[i] = 1'b1;
        end else begin : g_upper
            assign w_tgl_up[i] = w_tgl_up[i-1] &  r_q[i-1];
            assign w_tgl_dn[i] = w_tgl_dn[i-1] & ~r_q[i-1];
        end
    end

    always_comb begin
        w_q_nx = r_q;
        unique case (mode)
            c_mode_hold:   w_q_nx = r_q;
            c_mode_toggle: w_q_nx = r_q ^ t;
            c_mode_load:   w_q_nx = d;
            c_mode_count:  w_q_nx = r_q ^ (up ? w_tgl_up : w_tgl_dn);
            default:       w_q_nx = r_q;
        endcase
    end

    // Any operation that leaves q unchanged (toggle with t=0, load with d=q,
    // hold) counts as no change.
    assign w_chg      = (w_q_nx != r_q);
    assign w_cnt_full = &r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= RST_VAL;
            r_chg <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_q   <= w_q_nx;
            r_chg <= w_chg;
            // Clear wins over a simultaneous increment; the count saturates.
            if (clr_cnt) begin
                r_cnt <= '0;
            end else if (w_chg && !w_cnt_full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Terminal count looks at the current state and inputs only, so it is
    // visible before the wrapping edge.
    assign tc = (mode == c_mode_count) && (up ? (&r_q) : ~(|r_q));

    assign q       = r_q;
    assign chg     = r_chg;
    assign tog_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/toggle_bank.md
TOGGLE_BANK -- requirements
Module: toggle_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of T flip-flops in the bank; legal range 2 to 32.
REQ-002 Parameter CNT_W, default 4: width of the change-event counter; legal range 1 to 16.
REQ-003 Parameter RST_VAL, default 0: WIDTH-bit value loaded into q on reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  2  operation select: 00 hold, 01 toggle, 10 load, 11 count.
REQ-007 t  input  WIDTH  per-bit toggle mask, used in toggle mode only.
REQ-008 d  input  WIDTH  parallel load data, used in load mode only.
REQ-009 up  input  1  count direction in count mode: 1 up, 0 down.
REQ-010 clr_cnt  input  1  synchronous clear of tog_cnt.
REQ-011 q  output  WIDTH  registered flip-flop bank state.
REQ-012 tc  output  1  terminal-count flag, combinational.
REQ-013 chg  output  1  registered flag: q changed on the most recent rising edge.
REQ-014 tog_cnt  output  CNT_W  registered, saturating count of edges on which q changed.

Function
REQ-015 The block SHALL compute the next value q_nx combinationally from mode, and q SHALL load q_nx on every rising clk edge while rst_n=1.
REQ-016 mode 00: q_nx SHALL equal q.
REQ-017 mode 01: q_nx SHALL equal q XOR t; bit i SHALL toggle iff t[i]=1.
REQ-018 mode 10: q_nx SHALL equal d.
REQ-019 mode 11, up=1: q_nx SHALL equal (q+1) mod 2^WIDTH; each bit i SHALL toggle iff all bits below i are 1 (T-FF chain semantics).
REQ-020 mode 11, up=0: q_nx SHALL equal (q-1) mod 2^WIDTH; each bit i SHALL toggle iff all bits below i are 0.
REQ-021 Wrap-around: all-ones counting up SHALL go to 0; 0 counting down SHALL go to all-ones; no other side effect.
REQ-022 tc SHALL be 1 iff mode=11 and (up=1 and q=all-ones, or up=0 and q=0); otherwise 0.
REQ-023 t, d and up SHALL be ignored in modes where REQ-016 to REQ-020 do not reference them.
REQ-024 chg SHALL be registered as (q_nx != q) on each rising edge, so it is 1 for exactly the cycle following a change.
REQ-025 Any mode that yields q_nx = q SHALL produce chg=0 and no tog_cnt increment, including toggle with t=0 and load with d=q.
REQ-026 On each rising edge, tog_cnt SHALL go to 0 if clr_cnt=1; otherwise it SHALL increment by 1 if q_nx != q and tog_cnt is below all-ones; otherwise it SHALL hold.
REQ-027 clr_cnt SHALL take priority over a simultaneous increment; q and chg SHALL update normally during clr_cnt.
REQ-028 tog_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 Latency: a mode/data change at the inputs SHALL appear on q after the next rising edge and on chg/tog_cnt on the same edge; tc SHALL follow q and mode with no register delay.

Reset
REQ-030 When rst_n=0, the following SHALL be set immediately, independent of clk: q=RST_VAL, chg=0, tog_cnt=0.
REQ-031 While rst_n=0, all other inputs SHALL be ignored and the state SHALL hold at reset values.
REQ-032 Reset asserted mid-operation (any mode) SHALL abort it; no partial update SHALL survive.
REQ-033 After rst_n rises, the first state update SHALL occur on the next rising clk edge.

Verification (WIDTH=4, CNT_W=3, RST_VAL=0)
REQ-034 Reset, then mode=01, t=0101 for 2 edges -> q=0101, then q=0000; chg=1 both cycles; tog_cnt=2.
REQ-035 mode=10, d=1110, then mode=11, up=1 for 3 edges -> q=1110, 1111 (tc=1), 0000, 0001; tc=0 after the wrap.
REQ-036 From q=0000, mode=11, up=0 -> tc=1 before the edge; q=1111 after; then mode=00 for 2 edges -> q holds, chg=0, tog_cnt unchanged.
REQ-037 Run 10 changing edges with no clear -> tog_cnt saturates at 7; then clr_cnt=1 together with a changing edge -> tog_cnt=0, chg=1.
REQ-038 mode=10 with d=q, and mode=01 with t=0000 -> chg=0, tog_cnt holds.
REQ-039 Drop rst_n between clk edges during counting -> q=0000, chg=0, tog_cnt=0 before the next edge; release -> counting resumes from 0000 on the following edge.
